imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Serial (UART 8N1) program loader: the write side of instruction memory, which fetch only reads.
//  Receives a framed program image from a host, assembles big-endian 32-bit words and emits
//  one-cycle write strobes at incrementing byte addresses (multiples of 4). Holds the CPU in
//  reset while a load is in progress. Sits beside instr_mem/data_mem in top, on CLOCK_50.
// PARAMETERS
//  CLK_HZ      50000000  input clock frequency
//  BAUD        115200    serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division)
//  ADDR_W      8         word-address width; max image = 2**ADDR_W words
//  TIMEOUT_CYC 1000000   max idle cycles between bytes inside a frame before abort
// PORTS
//  clock       in   1   system clock, all logic on rising edge
//  reset       in   1   synchronous, active-low reset
//  rx          in   1   serial input, idle high, asynchronous to clock
//  start       in   1   one-cycle pulse: arm loader (ignored while busy)
//  cpu_hold    out  1   high from start accepted until DONE/ERR; drives CPU reset
//  wr_en       out  1   one-cycle write strobe
//  wr_addr     out  16  byte address of current word (word_index*4)
//  wr_data     out  32  assembled word, valid while wr_en=1
//  busy        out  1   FSM not in IDLE/DONE/ERR
//  done        out  1   sticky: image loaded and checksum matched
//  err         out  2   sticky: 0 none, 1 framing, 2 checksum, 3 length/timeout
// BEHAVIOUR
//  Reset (reset=0 at clock edge): every output 0, FSM=IDLE, counters/shift regs cleared;
//   takes effect mid-frame too; no partial word is written.
//  rx passes a 2-flop synchronizer; all decoding uses the synchronized copy (2-cycle latency).
//  Byte RX: falling edge on idle line -> wait CLKS_PER_BIT/2, re-sample; high = glitch, drop.
//   Then sample 8 data bits (LSB first) at CLKS_PER_BIT spacing, then stop bit.
//   Stop bit 0 -> framing error. Byte valid the cycle after stop sample.
//  Frame: 0xA5, LEN_HI, LEN_LO, LEN*4 data bytes (word MSB first), CHK = XOR of data bytes.
//  FSM: IDLE -start-> SYNC (cpu_hold=1, busy=1, done/err cleared).
//   SYNC: bytes != 0xA5 discarded; 0xA5 -> LEN_HI -> LEN_LO.
//   LEN_LO: N=0 -> CHK; N > 2**ADDR_W -> ERR(3); else DATA.
//   DATA: 4th byte of a word -> wr_en=1 next cycle with wr_addr=idx*4, idx++;
//    after word N -> CHK. wr_addr holds last value after strobe.
//   CHK: byte == running XOR -> DONE (done=1) else ERR(2). Writes already issued stand.
//   DONE/ERR: cpu_hold=0, busy=0; start re-arms (idx and XOR cleared).
//  Framing error in any non-IDLE state -> ERR(1). Byte gap > TIMEOUT_CYC after SYNC
//   has seen 0xA5 -> ERR(3). SYNC itself never times out.
//  start coincident with reset: reset wins. start while busy: ignored.
//  wr_en never asserted outside DATA; at most one strobe per 4 bytes.
// TESTING (CLK_HZ=1600, BAUD=100 -> 16 clk/bit)
//  1 start; send A5 00 02 DE AD BE EF 01 23 45 67 22 -> wr_en @addr0 data DEADBEEF,
//    @addr4 data 01234567; done=1, err=0, cpu_hold 1->0.
//  2 same image, CHK=23 -> both writes occur; err=2, done=0, cpu_hold=0.
//  3 start; send 00 A5 00 00 00 -> leading 00 ignored; N=0 -> done=1, no wr_en.
//  4 send A5 00 01 DE with stop bit 0 -> err=1, no wr_en, busy=0.
//  5 reset=0 after A5 00 02 DE AD -> all outputs 0; new start + test-1 image writes from addr 0.
//  6 rx low for 4 clocks then high -> no byte decoded; LEN=0x0101 with ADDR_W=8 -> err=3.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader bus: serial input and arm pulse in, write strobe and status out.
interface imem_loader_if;
    logic        i_rx;
    logic        i_start;
    logic        o_cpu_hold;
    logic        o_wr_en;
    logic [15:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_err;

    // Host / environment side
    modport master (
        output i_rx,
        output i_start,
        input  o_cpu_hold,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data,
        input  o_busy,
        input  o_done,
        input  o_err
    );

    // Loader side
    modport slave (
        input  i_rx,
        input  i_start,
        output o_cpu_hold,
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data,
        output o_busy,
        output o_done,
        output o_err
    );
endinterface

// File: rtl/imem_loader.sv
// UART 8N1 program loader: decodes a framed image (A5, LEN_HI, LEN_LO, data, XOR)
// into big-endian 32-bit word writes for instruction memory, holding the CPU
// in reset while a load is in progress.
module imem_loader #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic         i_clock,
    input  logic         i_reset,
    imem_loader_if.slave bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned GAP_W        = $clog2(TIMEOUT_CYC + 2);
    localparam int unsigned MAX_WORDS    = 32'd1 << ADDR_W;
    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

    localparam logic [1:0]  ERR_FRAME    = 2'd1;
    localparam logic [1:0]  ERR_CHK      = 2'd2;
    localparam logic [1:0]  ERR_LEN      = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    // ---------------------------------------------------------------
    // Serial receiver registers
    // ---------------------------------------------------------------
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_state_nxt;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [CNT_W-1:0] w_clk_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_byte_vld;
    logic             w_byte_vld_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;

    // ---------------------------------------------------------------
    // Frame FSM registers
    // ---------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_len;
    logic [15:0]      w_len_nxt;
    logic [15:0]      r_idx;
    logic [15:0]      w_idx_nxt;
    logic [23:0]      r_word;
    logic [23:0]      w_word_nxt;
    logic [1:0]       r_byte_idx;
    logic [1:0]       w_byte_idx_nxt;
    logic [7:0]       r_xor;
    logic [7:0]       w_xor_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;

    logic             r_cpu_hold;
    logic             w_cpu_hold_nxt;
    logic             r_wr_en;
    logic             w_wr_en_nxt;
    logic [15:0]      r_wr_addr;
    logic [15:0]      w_wr_addr_nxt;
    logic [31:0]      r_wr_data;
    logic [31:0]      w_wr_data_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [1:0]       r_err;
    logic [1:0]       w_err_nxt;

    logic [15:0]      w_len_full;
    logic             w_active;
    logic             w_timed;

    // Two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receiver state register
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rx_state <= RX_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_vld <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_byte_vld <= w_byte_vld_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    // Receiver next state: mid-bit sampling, glitch rejection, stop-bit check
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_clk_cnt_nxt  = r_clk_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_byte_vld_nxt = 1'b0;
        w_ferr_nxt     = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                w_clk_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_clk_cnt == CNT_W'(HALF_BIT - 1)) begin
                    w_clk_cnt_nxt  = '0;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_clk_cnt_nxt  = '0;
                    w_rx_state_nxt = RX_IDLE;
                    w_byte_vld_nxt = r_rx_sync;
                    w_ferr_nxt     = !r_rx_sync;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // Frame FSM and registered outputs
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_xor      <= '0;
            r_gap      <= '0;
            r_cpu_hold <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_word     <= w_word_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_xor      <= w_xor_nxt;
            r_gap      <= w_gap_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign w_len_full = {r_len[15:8], r_shift};
    assign w_active   = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
    // Byte-gap watchdog only runs once the sync byte has been seen
    assign w_timed    = w_active && (r_state != ST_SYNC);

    // Frame FSM next state: header parse, word assembly, checksum, abort paths
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_word_nxt     = r_word;
        w_byte_idx_nxt = r_byte_idx;
        w_xor_nxt      = r_xor;
        w_gap_nxt      = '0;
        w_cpu_hold_nxt = r_cpu_hold;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;

        if (w_timed && !r_byte_vld) begin
            w_gap_nxt = r_gap + GAP_W'(1);
        end

        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.i_start) begin
                    w_state_nxt    = ST_SYNC;
                    w_cpu_hold_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_err_nxt      = '0;
                    w_len_nxt      = '0;
                    w_idx_nxt      = '0;
                    w_word_nxt     = '0;
                    w_byte_idx_nxt = '0;
                    w_xor_nxt      = '0;
                end
            end
            ST_SYNC: begin
                if (r_byte_vld && (r_shift == SYNC_BYTE)) begin
                    w_state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (r_byte_vld) begin
                    w_len_nxt   = {r_shift, 8'h00};
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (r_byte_vld) begin
                    w_len_nxt = w_len_full;
                    if (w_len_full == 16'd0) begin
                        w_state_nxt = ST_CHK;
                    end else if (32'(w_len_full) > MAX_WORDS) begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = ERR_LEN;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (r_byte_vld) begin
                    w_xor_nxt  = r_xor ^ r_shift;
                    w_word_nxt = {r_word[15:0], r_shift};
                    if (r_byte_idx == 2'd3) begin
                        w_byte_idx_nxt = '0;
                        w_wr_en_nxt    = 1'b1;
                        w_wr_data_nxt  = {r_word, r_shift};
                        w_wr_addr_nxt  = {r_idx[13:0], 2'b00};
                        w_idx_nxt      = r_idx + 16'd1;
                        if ((r_idx + 16'd1) == r_len) begin
                            w_state_nxt = ST_CHK;
                        end
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                    end
                end
            end
            ST_CHK: begin
                if (r_byte_vld) begin
                    if (r_shift == r_xor) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = ERR_CHK;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_active && r_ferr) begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = ERR_FRAME;
            w_done_nxt  = 1'b0;
        end else if (w_timed && !r_byte_vld && (r_gap >= GAP_W'(TIMEOUT_CYC))) begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = ERR_LEN;
            w_done_nxt  = 1'b0;
        end

        if ((w_state_nxt == ST_DONE) || (w_state_nxt == ST_ERR)) begin
            w_cpu_hold_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
        end
    end

    assign bus.o_cpu_hold = r_cpu_hold;
    assign bus.o_wr_en    = r_wr_en;
    assign bus.o_wr_addr  = r_wr_addr;
    assign bus.o_wr_data  = r_wr_data;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_err      = r_err;

endmodule
